seq_magnitude_comparator: RTL and testbench
===========================================

Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit combinational magnitude comparator.
- Compares two WIDTH-bit operands CHUNK bits per clock, MSB chunk first.
- Terminates early at the first differing chunk.
- Adds a signed/unsigned mode and a start/busy/done handshake, so wide comparisons fit a tight timing budget in the datapath.

Parameters:
- WIDTH, 16, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived, not overridable; number of chunk steps.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a comparison; accepted only when busy=0.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- data_a  in  WIDTH  operand A; sampled with start.
- data_b  in  WIDTH  operand B; sampled with start.
- busy  out  1  comparison in progress.
- done  out  1  one-cycle pulse when a result becomes valid.
- aeqb  out  1  A == B (registered result).
- agtb  out  1  A > B (registered result).
- altb  out  1  A < B (registered result).
- cycles  out  clog2(NCHUNK)+1  number of chunk steps used by the last comparison.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, aeqb, agtb, altb = 0; cycles = 0.
  - Internal operand registers and chunk index are cleared.
  - Reset asserted mid-comparison aborts it; no done is produced.
- States: IDLE, COMPARE.
- IDLE:
  - start=1 at an edge latches data_a, data_b and signed_mode.
  - Sets idx = NCHUNK-1, clears aeqb/agtb/altb/cycles, enters COMPARE.
  - busy=1 from that edge.
- COMPARE, each edge:
  - Compare chunk idx, i.e. bits [idx*CHUNK+CHUNK-1 : idx*CHUNK]; cycles increments by 1.
  - Signed mode, top chunk only (idx = NCHUNK-1): compare with the MSB of each operand inverted. This is equivalent to a signed compare; lower chunks are always compared unsigned.
  - Chunk A > chunk B: agtb=1, done=1, busy=0, go to IDLE.
  - Chunk A < chunk B: altb=1, done=1, busy=0, go to IDLE.
  - Chunks equal and idx = 0: aeqb=1, done=1, busy=0, go to IDLE.
  - Chunks equal and idx > 0: idx decrements, stay in COMPARE.
- Latency:
  - done rises k edges after the start-accept edge.
  - k = 1-based position, from the MSB end, of the first differing chunk.
  - k = NCHUNK when A == B.
  - On completion, cycles = k.
- done lasts exactly one cycle.
- aeqb/agtb/altb/cycles hold their values until the next start is accepted.
- At most one of aeqb/agtb/altb is 1 at any time. All three are 0 while busy and after reset.
- start while busy=1 is ignored. Latched operands do not change if data_a/data_b change mid-compare.
- start in the same cycle done=1 is accepted, because the state is already IDLE. This gives back-to-back operation with no bubble.
- CHUNK = WIDTH degenerates to a 1-cycle registered comparator (k = 1 always).

Test Plan (WIDTH=16, CHUNK=4):
- Unsigned, A=0x4000, B=0x3FFF, start pulse -> done 1 cycle after accept, agtb=1, cycles=1, busy high for 1 cycle.
- Unsigned, A=B=0xA5A5 -> done after 4 cycles, aeqb=1, cycles=4. Then A=0x1234, B=0x1235 -> altb=1 after 4 cycles.
- A=0x8000, B=0x0001:
  - signed_mode=1 -> altb=1, cycles=1.
  - signed_mode=0 -> agtb=1, cycles=1.
  - Also A=0xFFFF, B=0xFFFE signed -> agtb=1 after 4 cycles.
- Start A=0x0010, B=0x0020; hold start high and change operands to A=0xFFFF, B=0 while busy -> no restart, altb=1, cycles=3. start still high on the done cycle -> new compare of 0xFFFF vs 0 accepted, agtb=1 one cycle later.
- Start A=B=0x7777, then drive rst_n=0 after 2 cycles -> busy/done/results/cycles = 0 immediately; no done pulse. After release, A=3, B=4 -> altb=1, cycles=4.
- Random sweep, 1000 operand pairs in both modes against a reference model -> exact flag match, one-hot flags at done, cycles equal to the first-differing-chunk position.

Source files
------------

// File: rtl/seq_magnitude_comparator_if.sv
// rtl/seq_magnitude_comparator_if.sv - start/busy/done handshake and result bundle for the chunked comparator
interface seq_magnitude_comparator_if #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = $clog2(NCHUNK) + 1;

   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic             busy;
   logic             done;
   logic             aeqb;
   logic             agtb;
   logic             altb;
   logic [CW-1:0]    cycles;

   modport master (
      output start, signed_mode, data_a, data_b,
      input  busy, done, aeqb, agtb, altb, cycles
   );

   modport slave (
      input  start, signed_mode, data_a, data_b,
      output busy, done, aeqb, agtb, altb, cycles
   );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - multi-cycle magnitude comparator, CHUNK bits per clock, MSB chunk first
module seq_magnitude_comparator #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic                       clk,
   input logic                       rst_n,
   seq_magnitude_comparator_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = $clog2(NCHUNK) + 1;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

   typedef enum logic {IDLE, COMPARE} state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             sm_q, sm_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             done_q, done_d;
   logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
   logic [CW-1:0]    cyc_q, cyc_d;
   logic [CHUNK-1:0] ca, cb;

   // Operands shift left each step, so the chunk under test always sits at the top.
   // Flipping both sign bits on the top chunk turns the signed compare into an unsigned one.
   always_comb begin
      ca = a_q[WIDTH-1 -: CHUNK];
      cb = b_q[WIDTH-1 -: CHUNK];
      if (sm_q && (idx_q == IDX_TOP)) begin
         ca[CHUNK-1] = ~ca[CHUNK-1];
         cb[CHUNK-1] = ~cb[CHUNK-1];
      end
   end

   always_comb begin
      state_d = state;
      a_d     = a_q;
      b_d     = b_q;
      sm_d    = sm_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      eq_d    = eq_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      cyc_d   = cyc_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.data_a;
               b_d     = bus.data_b;
               sm_d    = bus.signed_mode;
               idx_d   = IDX_TOP;
               eq_d    = 1'b0;
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               cyc_d   = '0;
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            cyc_d = cyc_q + CW'(1);
            if ((ca != cb) || (idx_q == '0)) begin
               done_d  = 1'b1;
               gt_d    = (ca > cb);
               lt_d    = (ca < cb);
               eq_d    = (ca == cb);
               state_d = IDLE;
            end else begin
               idx_d = idx_q - IW'(1);
               a_d   = a_q << CHUNK;
               b_d   = b_q << CHUNK;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sm_q   <= 1'b0;
         idx_q  <= '0;
         done_q <= 1'b0;
         eq_q   <= 1'b0;
         gt_q   <= 1'b0;
         lt_q   <= 1'b0;
         cyc_q  <= '0;
      end else begin
         state  <= state_d;
         a_q    <= a_d;
         b_q    <= b_d;
         sm_q   <= sm_d;
         idx_q  <= idx_d;
         done_q <= done_d;
         eq_q   <= eq_d;
         gt_q   <= gt_d;
         lt_q   <= lt_d;
         cyc_q  <= cyc_d;
      end
   end

   assign bus.busy   = (state == COMPARE);
   assign bus.done   = done_q;
   assign bus.aeqb   = eq_q;
   assign bus.agtb   = gt_q;
   assign bus.altb   = lt_q;
   assign bus.cycles = cyc_q;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - vector table, corner sequences and random sweep for seq_magnitude_comparator
module tb_seq_magnitude_comparator;
   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   seq_magnitude_comparator_if #(.WIDTH(WIDTH), .CHUNK(CHUNK)) bus ();
   seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // flags are packed {aeqb, agtb, altb}
   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             sm;
      logic [2:0]       flags;
      int               k;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sm, output logic [2:0] flags, output int k);
      logic [WIDTH-1:0] x;
      int msb;
      logic gt, lt;
      if (sm) begin
         gt = $signed(a) > $signed(b);
         lt = $signed(a) < $signed(b);
      end else begin
         gt = a > b;
         lt = a < b;
      end
      flags = {a == b, gt, lt};
      x = a ^ b;
      msb = -1;
      for (int i = 0; i < WIDTH; i++) if (x[i]) msb = i;
      k = (msb < 0) ? NCHUNK : NCHUNK - msb / CHUNK;
   endfunction

   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < NCHUNK + 4) begin
         @(negedge clk);
         lat++;
         if (bus.done) break;
      end
   endtask

   task automatic run_one(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sm, input logic [2:0] ef, input int ek);
      int lat;
      logic [2:0] held;
      @(negedge clk);
      bus.start = 1'b1;
      bus.data_a = a;
      bus.data_b = b;
      bus.signed_mode = sm;
      @(negedge clk);
      bus.start = 1'b0;
      bus.data_a = WIDTH'($urandom);
      bus.data_b = WIDTH'($urandom);
      bus.signed_mode = ~sm;
      check({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
      check({tag, " flags_clear_while_busy"}, 32'({bus.aeqb, bus.agtb, bus.altb}), 32'd0);
      wait_done(lat);
      check({tag, " latency"}, 32'(lat), 32'(ek));
      check({tag, " flags"}, 32'({bus.aeqb, bus.agtb, bus.altb}), 32'(ef));
      check({tag, " onehot"}, 32'($countones({bus.aeqb, bus.agtb, bus.altb})), 32'd1);
      check({tag, " cycles"}, 32'(bus.cycles), 32'(ek));
      check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
      held = {bus.aeqb, bus.agtb, bus.altb};
      @(negedge clk);
      check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
      check({tag, " flags_hold"}, 32'({bus.aeqb, bus.agtb, bus.altb}), 32'(held));
   endtask

   vec_t vecs[$];
   int   lat;
   int   done_seen;

   initial begin
      vecs.push_back('{16'h4000, 16'h3FFF, 1'b0, 3'b010, 1});
      vecs.push_back('{16'hA5A5, 16'hA5A5, 1'b0, 3'b100, 4});
      vecs.push_back('{16'h1234, 16'h1235, 1'b0, 3'b001, 4});
      vecs.push_back('{16'h8000, 16'h0001, 1'b1, 3'b001, 1});
      vecs.push_back('{16'h8000, 16'h0001, 1'b0, 3'b010, 1});
      vecs.push_back('{16'hFFFF, 16'hFFFE, 1'b1, 3'b010, 4});
      vecs.push_back('{16'h7FFF, 16'h8000, 1'b1, 3'b010, 1});
      vecs.push_back('{16'h0000, 16'h0000, 1'b1, 3'b100, 4});
      vecs.push_back('{16'h0150, 16'h0160, 1'b1, 3'b001, 3});

      bus.start = 1'b0;
      bus.signed_mode = 1'b0;
      bus.data_a = '0;
      bus.data_b = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset flags", 32'({bus.aeqb, bus.agtb, bus.altb}), 32'd0);
      check("reset cycles", 32'(bus.cycles), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm,
                                vecs[i].flags, vecs[i].k);

      // start held high through a compare, operands changed mid-flight
      @(negedge clk);
      bus.start = 1'b1;
      bus.signed_mode = 1'b0;
      bus.data_a = 16'h0010;
      bus.data_b = 16'h0020;
      @(negedge clk);
      bus.data_a = 16'hFFFF;
      bus.data_b = 16'h0000;
      check("hold busy", 32'(bus.busy), 32'd1);
      wait_done(lat);
      check("hold latency", 32'(lat), 32'd3);
      check("hold flags", 32'({bus.aeqb, bus.agtb, bus.altb}), 32'b001);
      check("hold cycles", 32'(bus.cycles), 32'd3);
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b busy", 32'(bus.busy), 32'd1);
      check("b2b flags_clear", 32'({bus.aeqb, bus.agtb, bus.altb}), 32'd0);
      check("b2b cycles_clear", 32'(bus.cycles), 32'd0);
      @(negedge clk);
      check("b2b done", 32'(bus.done), 32'd1);
      check("b2b flags", 32'({bus.aeqb, bus.agtb, bus.altb}), 32'b010);
      check("b2b cycles", 32'(bus.cycles), 32'd1);

      // reset in the middle of a compare
      @(negedge clk);
      bus.start = 1'b1;
      bus.data_a = 16'h7777;
      bus.data_b = 16'h7777;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      check("abort flags", 32'({bus.aeqb, bus.agtb, bus.altb}), 32'd0);
      check("abort cycles", 32'(bus.cycles), 32'd0);
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 1) rst_n = 1'b1;
         if (bus.done) done_seen++;
      end
      check("abort no_done", 32'(done_seen), 32'd0);
      run_one("after_reset", 16'h0003, 16'h0004, 1'b0, 3'b001, 4);

      for (int i = 0; i < 1000; i++) begin
         for (int m = 0; m < 2; m++) begin
            logic [WIDTH-1:0] a, b;
            logic [2:0] ef;
            int ek;
            a = WIDTH'($urandom);
            case ($urandom_range(0, 3))
               0: b = WIDTH'($urandom);
               1: b = a;
               2: b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
               default: b = a ^ WIDTH'($urandom_range(0, 255));
            endcase
            model(a, b, m[0], ef, ek);
            run_one($sformatf("rand%0d_m%0d a=%h b=%h", i, m, a, b), a, b, m[0], ef, ek);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
